mem_access_unit: RTL and testbench

- CPU-side bus master that sits directly upstream of the memory controller and drives its shared tri-state data bus, address, rw and valid.
- Accepts load/store requests from the execute stage into a small in-order request FIFO.
- Sequences one bus transaction at a time, inserting a bus-turnaround cycle after reads and waiting a fixed read latency for load data.
- Returns one in-order response per request; misaligned accesses are rejected without a bus cycle.

---
 rtl/mem_access_unit.sv | 113 +++++++++++
 tb/tb_mem_access_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: in-order load/store bus master with request FIFO, read latency wait and bus turnaround.
// Optional perf counters enabled by defining MEM_ACCESS_UNIT_PERF_EN.
module mem_access_unit #(
  parameter int DWIDTH     = 32,
  parameter int CPUAWIDTH  = 32,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [CPUAWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0]    req_wdata,
  output logic                 resp_valid,
  output logic [DWIDTH-1:0]    resp_rdata,
  output logic                 resp_err,
  inout  wire  [DWIDTH-1:0]    mem_data,
  output logic [CPUAWIDTH-1:0] mem_addr,
  output logic                 mem_rw,
  output logic                 mem_valid
`ifdef MEM_ACCESS_UNIT_PERF_EN
  ,
  output logic [31:0]          perf_rd_cnt,
  output logic [31:0]          perf_wr_cnt,
  output logic [31:0]          perf_err_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RD_WAIT, TURN} state_t;
  state_t r_state, w_next;
  logic                 r_fifo_we    [FIFO_DEPTH];
  logic [CPUAWIDTH-1:0] r_fifo_addr  [FIFO_DEPTH];
  logic [DWIDTH-1:0]    r_fifo_wdata [FIFO_DEPTH];
  logic [AW-1:0]        r_wp, r_rp;
  logic [AW:0]          r_cnt;
  logic [2:0]           r_lat;
  logic [CPUAWIDTH-1:0] r_addr;
  logic                 r_resp_valid, r_resp_err;
  logic [DWIDTH-1:0]    r_resp_rdata;
  logic                 w_enq, w_deq, w_mis, w_issue, w_store, w_rd_done, w_head_we;
  logic [CPUAWIDTH-1:0] w_head_addr;
  logic [DWIDTH-1:0]    w_head_wdata;
  assign w_head_we    = r_fifo_we[r_rp];
  assign w_head_addr  = r_fifo_addr[r_rp];
  assign w_head_wdata = r_fifo_wdata[r_rp];
  assign req_ready    = r_cnt != (AW+1)'(FIFO_DEPTH);
  assign w_enq        = req_valid && req_ready;
  assign w_deq        = r_state == IDLE && r_cnt != '0;
  assign w_mis        = w_head_addr[1:0] != 2'b00;
  assign w_issue      = w_deq && !w_mis;
  assign w_store      = w_issue && w_head_we;
  // capture happens in the RD_WAIT cycle whose counter is about to hit zero
  assign w_rd_done    = r_state == RD_WAIT && r_lat == 3'd1;
  assign mem_valid    = w_issue;
  assign mem_rw       = !w_store;
  assign mem_addr     = w_issue ? w_head_addr : r_addr;
  assign mem_data     = w_store ? w_head_wdata : {DWIDTH{1'bz}};
  assign resp_valid   = r_resp_valid;
  assign resp_err     = r_resp_err;
  assign resp_rdata   = r_resp_rdata;
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (w_issue && !w_head_we) w_next = RD_WAIT;
    else if (w_rd_done) w_next = TURN;
    else if (r_state != IDLE && r_state != RD_WAIT) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp         <= '0;
      r_rp         <= '0;
      r_cnt        <= '0;
      r_lat        <= '0;
      r_addr       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      if (w_enq) begin
        r_fifo_we[r_wp]    <= req_we;
        r_fifo_addr[r_wp]  <= req_addr;
        r_fifo_wdata[r_wp] <= req_wdata;
        r_wp               <= r_wp + AW'(1);
      end
      if (w_deq) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_enq) - (AW+1)'(w_deq);
      if (w_issue) r_addr <= w_head_addr;
      if (w_issue && !w_head_we) r_lat <= 3'(RD_LATENCY);
      else if (r_state == RD_WAIT) r_lat <= r_lat - 3'd1;
      r_resp_valid <= (w_deq && (w_mis || w_head_we)) || w_rd_done;
      r_resp_err   <= w_deq && w_mis;
      r_resp_rdata <= w_rd_done ? mem_data : '0;
    end
  end
`ifdef MEM_ACCESS_UNIT_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_rd_cnt  <= '0;
      perf_wr_cnt  <= '0;
      perf_err_cnt <= '0;
    end else begin
      perf_rd_cnt  <= perf_rd_cnt + 32'(w_rd_done);
      perf_wr_cnt  <= perf_wr_cnt + 32'(w_store);
      perf_err_cnt <= perf_err_cnt + 32'(w_deq && w_mis);
    end
  end
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors for mem_access_unit with a latency-1 read model on the shared bus.
module tb_mem_access_unit;
  logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_rw, mem_valid;
  logic [31:0] resp_rdata, mem_addr;
  wire  [31:0] mem_data;
  logic        tb_drv = 1'b0;
  logic [31:0] tb_q = '0, rd_val = '0;
  int          n_tests = 0, n_fail = 0;
`ifdef MEM_ACCESS_UNIT_PERF_EN
  logic [31:0] perf_rd_cnt, perf_wr_cnt, perf_err_cnt;
`endif

  mem_access_unit #(.DWIDTH(32), .CPUAWIDTH(32), .RD_LATENCY(1), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_data(mem_data), .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_valid(mem_valid)
`ifdef MEM_ACCESS_UNIT_PERF_EN
    , .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_err_cnt(perf_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // memory side: return rd_val on the bus in the cycle after a read strobe
  assign mem_data = tb_drv ? tb_q : 32'hzzzz_zzzz;
  always @(posedge clk) begin
    tb_drv <= mem_valid && mem_rw;
    tb_q   <= rd_val;
  end

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata, rdval;
    logic        exp_valid, exp_rw;
    logic [31:0] exp_addr;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          lat;
  } vec_t;
  vec_t vecs[7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    chk($sformatf("v%0d_ready", idx), 32'(req_ready), 32'd1);
    rd_val = v.rdval;
    drive(1'b1, v.we, v.addr, v.wdata);
    tick;
    req_valid = 1'b0;
    chk($sformatf("v%0d_mem_valid", idx), 32'(mem_valid), 32'(v.exp_valid));
    chk($sformatf("v%0d_mem_rw", idx), 32'(mem_rw), 32'(v.exp_rw));
    chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.exp_addr);
    if (v.we && v.exp_valid) chk($sformatf("v%0d_mem_data", idx), mem_data, v.wdata);
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick;
      if (c == v.lat) begin
        chk($sformatf("v%0d_resp_valid", idx), 32'(resp_valid), 32'd1);
        chk($sformatf("v%0d_resp_err", idx), 32'(resp_err), 32'(v.exp_err));
        chk($sformatf("v%0d_resp_rdata", idx), resp_rdata, v.exp_rdata);
        if (!v.we && v.exp_valid) chk($sformatf("v%0d_turn_idle", idx), 32'(mem_valid), 32'd0);
      end else begin
        chk($sformatf("v%0d_no_resp_c%0d", idx, c), 32'(resp_valid), 32'd0);
      end
    end
    tick;
  endtask

  initial begin
    //         we    addr           wdata          rdval          vld   rw    exp_addr       err   rdata          lat
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b1, 1'b0, 32'h0000_0010, 1'b0, 32'h0,         2};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_0010, 1'b0, 32'hDEAD_BEEF, 3};
    vecs[2] = '{1'b0, 32'h0000_0013, 32'h0,         32'h7777_7777, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0,         2};
    vecs[3] = '{1'b1, 32'h0000_0012, 32'h1234_0000, 32'h0,         1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0,         2};
    vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h1234_5678, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h1234_5678, 3};
    vecs[5] = '{1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 32'h0,         1'b1, 1'b0, 32'h0000_0020, 1'b0, 32'h0,         2};
    vecs[6] = '{1'b0, 32'h0000_0021, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0020, 1'b1, 32'h0,         2};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_rw", 32'(mem_rw), 32'd1);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    tick;

    for (int i = 0; i < 7; i++) run_vec(i);

    // burst: load 0x0, store 0x4, store 0x8, then store 0xC held while full
    rd_val = 32'hCAFE_F00D;
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    tick;
    chk("b1_mem_valid", 32'(mem_valid), 32'd1);
    chk("b1_mem_rw", 32'(mem_rw), 32'd1);
    chk("b1_mem_addr", mem_addr, 32'h0);
    chk("b1_ready", 32'(req_ready), 32'd1);
    drive(1'b1, 1'b1, 32'h4, 32'h1111_1111);
    tick;
    chk("b2_mem_valid", 32'(mem_valid), 32'd0);
    chk("b2_ready", 32'(req_ready), 32'd1);
    drive(1'b1, 1'b1, 32'h8, 32'h2222_2222);
    tick;
    chk("b3_resp_valid", 32'(resp_valid), 32'd1);
    chk("b3_resp_rdata", resp_rdata, 32'hCAFE_F00D);
    chk("b3_mem_valid", 32'(mem_valid), 32'd0);
    chk("b3_ready_full", 32'(req_ready), 32'd0);
    drive(1'b1, 1'b1, 32'hC, 32'h3333_3333);
    tick;
    chk("b4_mem_valid", 32'(mem_valid), 32'd1);
    chk("b4_mem_rw", 32'(mem_rw), 32'd0);
    chk("b4_mem_addr", mem_addr, 32'h4);
    chk("b4_mem_data", mem_data, 32'h1111_1111);
    chk("b4_ready_full", 32'(req_ready), 32'd0);
    chk("b4_resp_valid", 32'(resp_valid), 32'd0);
    tick;
    chk("b5_mem_valid", 32'(mem_valid), 32'd1);
    chk("b5_mem_addr", mem_addr, 32'h8);
    chk("b5_mem_data", mem_data, 32'h2222_2222);
    chk("b5_resp_valid", 32'(resp_valid), 32'd1);
    chk("b5_ready", 32'(req_ready), 32'd1);
    tick;
    req_valid = 1'b0;
    chk("b6_mem_valid", 32'(mem_valid), 32'd1);
    chk("b6_mem_addr", mem_addr, 32'hC);
    chk("b6_mem_data", mem_data, 32'h3333_3333);
    chk("b6_resp_valid", 32'(resp_valid), 32'd1);
    tick;
    chk("b7_mem_valid", 32'(mem_valid), 32'd0);
    chk("b7_mem_addr_hold", mem_addr, 32'hC);
    chk("b7_resp_valid", 32'(resp_valid), 32'd1);
    chk("b7_resp_err", 32'(resp_err), 32'd0);
    tick;
    chk("b8_resp_valid", 32'(resp_valid), 32'd0);
    tick;

`ifdef MEM_ACCESS_UNIT_PERF_EN
    chk("perf_rd", perf_rd_cnt, 32'd3);
    chk("perf_wr", perf_wr_cnt, 32'd5);
    chk("perf_err", perf_err_cnt, 32'd3);
`endif

    // reset while a load waits for data, with a store still queued
    rd_val = 32'h5555_5555;
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    tick;
    chk("r1_mem_valid", 32'(mem_valid), 32'd1);
    drive(1'b1, 1'b1, 32'h44, 32'h9999_9999);
    tick;
    req_valid = 1'b0;
    reset     = 1'b1;
    tick;
    reset = 1'b0;
    chk("r_ready", 32'(req_ready), 32'd1);
`ifdef MEM_ACCESS_UNIT_PERF_EN
    chk("r_perf_rd", perf_rd_cnt, 32'd0);
    chk("r_perf_wr", perf_wr_cnt, 32'd0);
    chk("r_perf_err", perf_err_cnt, 32'd0);
`endif
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("r_no_resp_c%0d", c), 32'(resp_valid), 32'd0);
      chk($sformatf("r_no_strobe_c%0d", c), 32'(mem_valid), 32'd0);
      tick;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
